// File: rtl/m31_reduce_arbiter_pkg.sv
// Shared M31 field definitions (p = 2^31-1) for the reduce arbiter slice.
// Provides the modulus, element/wide-word types and the final canonicalisation step.
package m31_pkg;

    typedef logic [30:0] m31_t;
    typedef logic [61:0] m31_wide_t;

    localparam m31_t        M31_P  = 31'h7FFF_FFFF;
    localparam int unsigned WIDE_W = 62;

    // s2 is at most 2^31, so one conditional subtract of p is enough:
    // p maps to 0 and 2^31 maps to 1.
    function automatic m31_t m31_canon(input logic [31:0] s2);
        return (s2 >= {1'b0, M31_P}) ? m31_t'(s2 - {1'b0, M31_P}) : s2[30:0];
    endfunction

endpackage

// File: rtl/m31_reduce_arbiter_if.sv
// Request/result bundle for m31_reduce_arbiter.
// master = requester/consumer side, slave = the arbiter-reducer.
interface m31_reduce_arbiter_if
    import m31_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int IN_WIDTH = 62,
    parameter int ID_W     = $clog2(NUM_REQ)
);

    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ*IN_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]          req_ready;
    logic                        out_valid;
    logic                        out_ready;
    m31_t                        out_data;
    logic [ID_W-1:0]             out_id;

    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, out_id
    );

    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, out_id
    );

endinterface

// File: rtl/m31_reduce_arbiter_rr.sv
// Round-robin arbiter: search starts at ptr and wraps; ptr moves past the
// winner only when a grant is actually issued (advance high and a request present).
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    winner
);

    logic [ID_W-1:0] ptr;
    logic            found;

    // Two passes: indices at or above ptr first, then the wrapped lower part.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (!found && req[j] && (j >= 32'(ptr))) begin
                found  = 1'b1;
                winner = ID_W'(j);
            end
        end
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (!found && req[j] && (j < 32'(ptr))) begin
                found  = 1'b1;
                winner = ID_W'(j);
            end
        end
    end

    always_comb begin
        gnt = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            gnt[j] = advance && found && (winner == ID_W'(j));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);
        end
    end

endmodule

// File: rtl/m31_reduce_arbiter.sv
// Round-robin shared 3-stage M31 reducer with id-tagged canonical results.
// Optional M31_REDUCE_ARB_STATS_EN adds per-requester grant and stall counters.
module m31_reduce_arbiter
    import m31_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int IN_WIDTH = 62,
    parameter int ID_W     = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    m31_reduce_arbiter_if.slave     bus
`ifdef M31_REDUCE_ARB_STATS_EN
    ,
    output logic [NUM_REQ*32-1:0]   grant_cnt,
    output logic [31:0]             stall_cnt
`endif
);

    logic                en;
    logic                advance;
    logic                transfer;
    logic [NUM_REQ-1:0]  gnt;
    logic [ID_W-1:0]     winner;
    logic [IN_WIDTH-1:0] sel_word;
    m31_wide_t           w_in;

    m31_wide_t           w0;
    logic [ID_W-1:0]     id0, id1, id2;
    logic                v0, v1, v2;
    logic [31:0]         s1, s2;
    logic [31:0]         s1_next, s2_next;

    logic                out_valid_q;
    m31_t                out_data_q;
    logic [ID_W-1:0]     out_id_q;

    assign en      = !out_valid_q || bus.out_ready;
    // Gating with rst_n keeps req_ready low while reset is held.
    assign advance = en && rst_n;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (bus.req_valid),
        .advance (advance),
        .gnt     (gnt),
        .winner  (winner)
    );

    assign bus.req_ready = gnt;
    assign transfer      = |(gnt & bus.req_valid);

    always_comb begin
        sel_word = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (winner == ID_W'(j)) begin
                sel_word = bus.req_data[j*IN_WIDTH +: IN_WIDTH];
            end
        end
    end

    always_comb begin
        w_in                 = '0;
        w_in[IN_WIDTH-1:0]   = sel_word;
    end

    // 2^31 == 1 (mod p): fold the high half onto the low half, twice.
    assign s1_next = {1'b0, w0[30:0]} + {1'b0, w0[61:31]};
    assign s2_next = {1'b0, s1[30:0]} + {31'b0, s1[31]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w0          <= '0;
            id0         <= '0;
            v0          <= 1'b0;
            s1          <= '0;
            id1         <= '0;
            v1          <= 1'b0;
            s2          <= '0;
            id2         <= '0;
            v2          <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
        end else if (en) begin
            w0          <= w_in;
            id0         <= winner;
            v0          <= transfer;
            s1          <= s1_next;
            id1         <= id0;
            v1          <= v0;
            s2          <= s2_next;
            id2         <= id1;
            v2          <= v1;
            out_valid_q <= v2;
            out_data_q  <= m31_canon(s2);
            out_id_q    <= id2;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_id    = out_id_q;

`ifdef M31_REDUCE_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            for (int unsigned j = 0; j < NUM_REQ; j++) begin
                if (gnt[j] && bus.req_valid[j]) begin
                    grant_cnt[j*32 +: 32] <= grant_cnt[j*32 +: 32] + 32'd1;
                end
            end
            if (out_valid_q && !bus.out_ready) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_m31_reduce_arbiter.sv
// Self-checking bench for m31_reduce_arbiter: directed and random traffic
// against a queue-based reference using plain modular arithmetic.
module tb_m31_reduce_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int IN_WIDTH = 62;
    localparam int ID_W     = 2;
    localparam longint unsigned P = 64'h7FFF_FFFF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    m31_reduce_arbiter_if #(.NUM_REQ(NUM_REQ), .IN_WIDTH(IN_WIDTH), .ID_W(ID_W)) bus ();

`ifdef M31_REDUCE_ARB_STATS_EN
    logic [NUM_REQ*32-1:0] grant_cnt;
    logic [31:0]           stall_cnt;
`endif

    m31_reduce_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .IN_WIDTH (IN_WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave)
`ifdef M31_REDUCE_ARB_STATS_EN
        ,
        .grant_cnt (grant_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    typedef struct {
        int unsigned     id;
        longint unsigned val;
        int unsigned     age;
    } entry_t;

    entry_t          q[$];
    int unsigned     ptr_m;
    longint unsigned grants_m[NUM_REQ];
    longint unsigned stalls_m;
    int              errors = 0;
    int              checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [61:0] rnd_word();
        logic [63:0] r;
        r = {$urandom, $urandom};
        case ($urandom_range(0, 5))
            0:       return 62'h0000_0000_7FFF_FFFF;
            1:       return 62'h0000_0000_8000_0000;
            2:       return 62'h3FFF_FFFF_FFFF_FFFF;
            3:       return 62'h3FFF_FFFF_0000_0001;
            4:       return 62'(r[15:0]);
            default: return r[61:0];
        endcase
    endfunction

    function automatic logic [NUM_REQ*IN_WIDTH-1:0] rnd_bus();
        logic [NUM_REQ*IN_WIDTH-1:0] d;
        for (int i = 0; i < NUM_REQ; i++) d[i*IN_WIDTH +: IN_WIDTH] = rnd_word();
        return d;
    endfunction

    function automatic logic [NUM_REQ*IN_WIDTH-1:0] one_word(input int id, input logic [61:0] w);
        logic [NUM_REQ*IN_WIDTH-1:0] d;
        d = '0;
        d[id*IN_WIDTH +: IN_WIDTH] = w;
        return d;
    endfunction

    // One clock: drive at negedge, compare, then advance the reference on the edge.
    task automatic cycle(input logic [NUM_REQ-1:0] v, input logic [NUM_REQ*IN_WIDTH-1:0] d,
                         input logic rdy);
        bit              exp_ov;
        bit              en;
        int              win;
        logic [NUM_REQ-1:0] exp_rdy;
        logic [61:0]     w;
        entry_t          e;
        bus.req_valid = v;
        bus.req_data  = d;
        bus.out_ready = rdy;
        #1;
        exp_ov = (q.size() > 0) && (q[0].age >= 3);
        en     = !exp_ov || rdy;
        win    = -1;
        for (int k = 0; k < NUM_REQ; k++) begin
            int c;
            c = (int'(ptr_m) + k) % NUM_REQ;
            if (win < 0 && v[c]) win = c;
        end
        exp_rdy = '0;
        if (en && win >= 0) exp_rdy[win] = 1'b1;
        check("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
        check("out_valid", 64'(bus.out_valid), 64'(exp_ov));
        if (exp_ov) begin
            check("out_data", 64'(bus.out_data), q[0].val);
            check("out_id", 64'(bus.out_id), 64'(q[0].id));
        end
        if (exp_ov && !rdy) stalls_m++;
        @(posedge clk);
        if (en) begin
            if (exp_ov) void'(q.pop_front());
            foreach (q[j]) q[j].age++;
            if (win >= 0) begin
                w     = d[win*IN_WIDTH +: IN_WIDTH];
                e.id  = win;
                e.val = 64'(w) % P;
                e.age = 0;
                q.push_back(e);
                ptr_m = (win + 1) % NUM_REQ;
                grants_m[win]++;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle('0, '0, 1'b1);
    endtask

    task automatic check_stats();
`ifdef M31_REDUCE_ARB_STATS_EN
        for (int i = 0; i < NUM_REQ; i++)
            check("grant_cnt", 64'(grant_cnt[i*32 +: 32]), 64'(grants_m[i][31:0]));
        check("stall_cnt", 64'(stall_cnt), 64'(stalls_m[31:0]));
`endif
    endtask

    initial begin
        logic [NUM_REQ-1:0] v;
        ptr_m    = 0;
        stalls_m = 0;
        foreach (grants_m[i]) grants_m[i] = 0;
        bus.req_valid = '1;
        bus.req_data  = rnd_bus();
        bus.out_ready = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_data", 64'(bus.out_data), 64'd0);
        check("rst_out_id", 64'(bus.out_id), 64'd0);
        check("rst_req_ready", 64'(bus.req_ready), 64'd0);
        check_stats();
        @(negedge clk);
        rst_n = 1'b1;

        // Boundary words from requester 0: p, 2^31, p^2.
        cycle(4'b0001, one_word(0, 62'h0000_0000_7FFF_FFFF), 1'b1);
        cycle(4'b0001, one_word(0, 62'h0000_0000_8000_0000), 1'b1);
        cycle(4'b0001, one_word(0, 62'h3FFF_FFFF_0000_0001), 1'b1);
        idle(5);

        cycle(4'b0100, one_word(2, 62'h3FFF_FFFF_FFFF_FFFF), 1'b1);
        cycle(4'b0010, one_word(1, 62'h0000_0001_0000_0005), 1'b1);
        cycle(4'b1000, one_word(3, 62'd123456789), 1'b1);
        idle(5);

        // All requesters busy: strict rotation.
        for (int i = 0; i < 12; i++) cycle(4'b1111, rnd_bus(), 1'b1);
        idle(5);

        // Move ptr to 2, then only 1 and 3 request.
        cycle(4'b0010, rnd_bus(), 1'b1);
        for (int i = 0; i < 4; i++) cycle(4'b1010, rnd_bus(), 1'b1);
        idle(5);

        // Ten-word stream with a 5-cycle backpressure hole.
        for (int i = 0; i < 4; i++) cycle(4'(1 << $urandom_range(0, 3)), rnd_bus(), 1'b1);
        for (int i = 0; i < 5; i++) cycle(4'b1111, rnd_bus(), 1'b0);
        for (int i = 0; i < 6; i++) cycle(4'(1 << $urandom_range(0, 3)), rnd_bus(), 1'b1);
        idle(6);

        // Random traffic and random backpressure.
        for (int i = 0; i < 200; i++) begin
            v = 4'($urandom_range(0, 15));
            cycle(v, rnd_bus(), ($urandom_range(0, 3) != 0));
        end
        idle(8);
        check_stats();

        // Reset with words in flight; the held result must vanish at once.
        for (int i = 0; i < 4; i++) cycle(4'b1111, rnd_bus(), 1'b1);
        #1;
        check("pre_rst_out_valid", 64'(bus.out_valid), 64'((q.size() > 0) && (q[0].age >= 3)));
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("async_rst_req_ready", 64'(bus.req_ready), 64'd0);
        q.delete();
        ptr_m    = 0;
        stalls_m = 0;
        foreach (grants_m[i]) grants_m[i] = 0;
        check_stats();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(6);
        for (int i = 0; i < 3; i++) cycle(4'b1111, rnd_bus(), 1'b1);
        idle(6);
        check_stats();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
